m_frame_scheduler: RTL and testbench
====================================

M_FRAME_SCHEDULER -- requirements
Module: m_frame_scheduler

Interface
REQ-001 Parameter: TICK_DIV, default 833333, meaning clock cycles per frame tick (50 MHz / 60 Hz).
REQ-002 Parameter: WD_LIMIT, default 4095, meaning the maximum number of RENDER cycles before the watchdog aborts.
REQ-003 Port: clock  in  1  the single system clock.
REQ-004 Port: resetn  in  1  reset, asynchronous, active-low.
REQ-005 Port: game_step  out  1  one-cycle pulse requesting one game-logic update.
REQ-006 Port: game_done  in  1  game logic has finished its update (level or pulse).
REQ-007 Port: in_pos  in  36  live positions, packed {pl_x[4:0], pl_y[3:0], g1, g2, g3}, 9 bits per sprite.
REQ-008 Port: out_pos  out  36  frame-stable snapshot of in_pos, driven to the renderer.
REQ-009 Port: rd_enable  out  1  renderer enable.
REQ-010 Port: rd_finished  in  1  renderer done flag.
REQ-011 Port: rd_x / rd_y / rd_color  in  8/7/12  renderer pixel bus.
REQ-012 Port: ov_req / ov_done  in  1/1  overlay (score/text) writer request and completion.
REQ-013 Port: ov_grant  out  1  overlay owns the VGA port.
REQ-014 Port: ov_plot, ov_x, ov_y, ov_color  in  1/8/7/12  overlay pixel bus.
REQ-015 Port: vga_plot, vga_x, vga_y, vga_color  out  1/8/7/12  arbitrated pixel write port.
REQ-016 Port: frame_count  out  16  number of completed frames.
REQ-017 Port: overrun_count  out  8  number of missed frame ticks.
REQ-018 Port: wd_err  out  1  sticky watchdog error flag.

Function
REQ-019 Tick counter: 0..TICK_DIV-1, wrapping; tick is asserted for one cycle when the counter equals TICK_DIV-1.
REQ-020 FSM states: WAIT_TICK, UPDATE, SNAPSHOT, RENDER, OVERLAY.
REQ-021 WAIT_TICK -> UPDATE on tick; game_step pulses high in the first UPDATE cycle only.
REQ-022 UPDATE -> SNAPSHOT on the first cycle where game_done=1 and the cycle is after the pulse; game_done in the pulse cycle itself is ignored.
REQ-023 SNAPSHOT: out_pos <= in_pos, one cycle, then -> RENDER; out_pos holds its value in all other states.
REQ-024 RENDER: rd_enable=1; on rd_finished=1, rd_enable=0 from the next cycle and -> OVERLAY.
REQ-025 OVERLAY: if ov_req=0 on entry, -> WAIT_TICK next cycle; otherwise ov_grant=1 until ov_done=1, then ov_grant=0 and -> WAIT_TICK.
REQ-026 frame_count increments by 1, wrapping at 16 bits, on every exit from OVERLAY.
REQ-027 A tick seen in any state other than WAIT_TICK increments overrun_count, saturating at 255; that tick is dropped and not queued.
REQ-028 Pixel mux, combinational: in RENDER, vga_plot=1 and vga_x/vga_y/vga_color are taken from rd_*.
REQ-029 Pixel mux: in OVERLAY with ov_grant=1, vga_plot=ov_plot and vga_x/vga_y/vga_color are taken from ov_*.
REQ-030 Pixel mux: in all other cases, vga_plot=0 and vga_x/vga_y/vga_color are 0.
REQ-031 The overlay is never granted while rd_enable=1; ov_req arriving outside OVERLAY waits for the next OVERLAY state.

Reset
REQ-032 While resetn=0: state=WAIT_TICK, tick counter=0, and every output is 0, including out_pos, counters and wd_err.
REQ-033 Reset asserted mid-RENDER or mid-OVERLAY drops rd_enable and ov_grant immediately, asynchronously.
REQ-034 After resetn rises, the first tick occurs after TICK_DIV cycles.

Configuration
REQ-035 Macro FRAME_WATCHDOG_EN defined: a cycle counter runs in RENDER.
REQ-036 With FRAME_WATCHDOG_EN defined: if RENDER reaches WD_LIMIT cycles without rd_finished, rd_enable=0, wd_err=1 (sticky until reset), -> WAIT_TICK, and frame_count is not incremented.
REQ-037 Macro FRAME_WATCHDOG_EN undefined: no watchdog counter is built, wd_err is tied to 0, and RENDER waits indefinitely.

Verification (bench uses TICK_DIV=16, WD_LIMIT=64)
REQ-038 Normal frame: reset release; game_done 3 cycles after game_step; rd_finished after 50 cycles; ov_req=0 -> game_step pulse at cycle 16, out_pos equals in_pos sampled in SNAPSHOT, vga_plot high for exactly the RENDER cycles, frame_count=1.
REQ-039 Overlay: ov_req=1, ov_done 10 cycles after grant, ov_plot toggling -> vga_* follows ov_* only while ov_grant=1, ov_grant never overlaps rd_enable, frame_count increments after ov_done.
REQ-040 Overrun: rd_finished delayed 40 cycles -> overrun_count=1 per skipped tick; overrun_count saturates at 255 after 300 forced overruns.
REQ-041 Snapshot stability: in_pos changes every cycle during RENDER -> out_pos constant throughout RENDER.
REQ-042 Watchdog (FRAME_WATCHDOG_EN): rd_finished held 0 -> rd_enable falls after 64 RENDER cycles, wd_err=1, frame_count unchanged; without the macro, rd_enable stays 1 and wd_err=0.
REQ-043 Reset mid-RENDER: resetn low at RENDER cycle 5 -> rd_enable, vga_plot, frame_count and overrun_count are 0 the same cycle.

Source files
------------

// File: rtl/m_frame_scheduler.sv
// m_frame_scheduler
// Paces a game/render loop to a fixed frame tick. Each tick requests one
// game-logic update, freezes the sprite positions for the renderer, runs the
// renderer, then lends the VGA write port to an overlay writer if it asks.
//
// Ports
//   clock, resetn                 system clock, async active-low reset
//   game_step / game_done         update request pulse / update complete
//   in_pos / out_pos              live sprite positions / frame-stable copy
//   rd_enable / rd_finished       renderer enable / renderer done
//   rd_x, rd_y, rd_color          renderer pixel bus
//   ov_req, ov_done / ov_grant    overlay request, completion / grant
//   ov_plot, ov_x, ov_y, ov_color overlay pixel bus
//   vga_plot, vga_x, vga_y, vga_color  arbitrated pixel write port
//   frame_count, overrun_count    completed frames / dropped ticks (saturating)
//   wd_err                        sticky render watchdog error
//
// Build option: define FRAME_WATCHDOG_EN to abort a RENDER phase that lasts
// WD_LIMIT cycles without rd_finished. Without it wd_err is tied low and
// RENDER waits for rd_finished indefinitely.
//
// state     | meaning
// WAIT_TICK | idle until the next frame tick
// UPDATE    | game_step pulsed, waiting for game_done
// SNAPSHOT  | copy in_pos into out_pos
// RENDER    | renderer owns the VGA port
// OVERLAY   | optional overlay writer owns the VGA port
module m_frame_scheduler #(
   parameter int TICK_DIV = 833333,
   parameter int WD_LIMIT = 4095
) (
   input  logic        clock,
   input  logic        resetn,
   output logic        game_step,
   input  logic        game_done,
   input  logic [35:0] in_pos,
   output logic [35:0] out_pos,
   output logic        rd_enable,
   input  logic        rd_finished,
   input  logic [7:0]  rd_x,
   input  logic [6:0]  rd_y,
   input  logic [11:0] rd_color,
   input  logic        ov_req,
   input  logic        ov_done,
   output logic        ov_grant,
   input  logic        ov_plot,
   input  logic [7:0]  ov_x,
   input  logic [6:0]  ov_y,
   input  logic [11:0] ov_color,
   output logic        vga_plot,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [11:0] vga_color,
   output logic [15:0] frame_count,
   output logic [7:0]  overrun_count,
   output logic        wd_err
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   if (TICK_DIV < 1 || WD_LIMIT < 1) begin : g_param_check
      $error("m_frame_scheduler: TICK_DIV and WD_LIMIT must be at least 1");
   end

   typedef enum logic [2:0] {
      WAIT_TICK = 3'd0,
      UPDATE    = 3'd1,
      SNAPSHOT  = 3'd2,
      RENDER    = 3'd3,
      OVERLAY   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          first_q;
   logic          frame_done;
   logic          wd_timeout;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)   tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   // first_q marks the first cycle spent in a state; it gates the game_step
   // pulse and the overlay's entry-time request check.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= WAIT_TICK;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= (state_d != state_q);
      end
   end

   assign game_step = (state_q == UPDATE) && first_q;
   assign rd_enable = (state_q == RENDER);
   // Past the entry cycle the grant is already held, so only entry looks at ov_req.
   assign ov_grant  = (state_q == OVERLAY) && (ov_req || !first_q);

   always_comb begin
      state_d    = state_q;
      frame_done = 1'b0;
      case (state_q)
         WAIT_TICK: if (tick) state_d = UPDATE;
         UPDATE:    if (game_done && !first_q) state_d = SNAPSHOT;
         SNAPSHOT:  state_d = RENDER;
         RENDER: begin
            if (rd_finished)     state_d = OVERLAY;
            else if (wd_timeout) state_d = WAIT_TICK;
         end
         OVERLAY: begin
            if (!ov_grant || ov_done) begin
               state_d    = WAIT_TICK;
               frame_done = 1'b1;
            end
         end
         default: state_d = WAIT_TICK;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_pos       <= '0;
         frame_count   <= '0;
         overrun_count <= '0;
      end else begin
         if (state_q == SNAPSHOT) out_pos <= in_pos;
         if (frame_done) frame_count <= frame_count + 16'd1;
         if (tick && (state_q != WAIT_TICK) && (overrun_count != 8'hFF))
            overrun_count <= overrun_count + 8'd1;
      end
   end

`ifdef FRAME_WATCHDOG_EN
   localparam int WW = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
   localparam logic [WW-1:0] WD_LOAD = WW'(WD_LIMIT - 1);

   logic [WW-1:0] wd_cnt;
   logic          wd_err_q;

   // Reloaded outside RENDER; reaches zero on the WD_LIMIT-th RENDER cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                  wd_cnt <= '0;
      else if (state_q != RENDER)   wd_cnt <= WD_LOAD;
      else if (wd_cnt != '0)        wd_cnt <= wd_cnt - 1'b1;
   end

   assign wd_timeout = (state_q == RENDER) && (wd_cnt == '0) && !rd_finished;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)         wd_err_q <= 1'b0;
      else if (wd_timeout) wd_err_q <= 1'b1;
   end

   assign wd_err = wd_err_q;
`else
   assign wd_timeout = 1'b0;
   assign wd_err     = 1'b0;
`endif

   always_comb begin
      vga_plot  = 1'b0;
      vga_x     = '0;
      vga_y     = '0;
      vga_color = '0;
      if (state_q == RENDER) begin
         vga_plot  = 1'b1;
         vga_x     = rd_x;
         vga_y     = rd_y;
         vga_color = rd_color;
      end else if (ov_grant) begin
         vga_plot  = ov_plot;
         vga_x     = ov_x;
         vga_y     = ov_y;
         vga_color = ov_color;
      end
   end

endmodule

// File: tb/tb_m_frame_scheduler.sv
// tb_m_frame_scheduler
// Directed bench for m_frame_scheduler with TICK_DIV=16, WD_LIMIT=64.
// Cycle k means the k-th falling edge after resetn rises; outputs are sampled
// on falling edges and inputs are changed right after sampling.
module tb_m_frame_scheduler;
   localparam int TICK_DIV = 16;
   localparam int WD_LIMIT = 64;

   logic        clock, resetn;
   logic        game_step, game_done;
   logic [35:0] in_pos, out_pos;
   logic        rd_enable, rd_finished;
   logic [7:0]  rd_x;
   logic [6:0]  rd_y;
   logic [11:0] rd_color;
   logic        ov_req, ov_done, ov_grant, ov_plot;
   logic [7:0]  ov_x;
   logic [6:0]  ov_y;
   logic [11:0] ov_color;
   logic        vga_plot;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [11:0] vga_color;
   logic [15:0] frame_count;
   logic [7:0]  overrun_count;
   logic        wd_err;

   int checks = 0;
   int failures = 0;

   m_frame_scheduler #(.TICK_DIV(TICK_DIV), .WD_LIMIT(WD_LIMIT)) dut (
      .clock(clock), .resetn(resetn),
      .game_step(game_step), .game_done(game_done),
      .in_pos(in_pos), .out_pos(out_pos),
      .rd_enable(rd_enable), .rd_finished(rd_finished),
      .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color),
      .ov_req(ov_req), .ov_done(ov_done), .ov_grant(ov_grant),
      .ov_plot(ov_plot), .ov_x(ov_x), .ov_y(ov_y), .ov_color(ov_color),
      .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
      .frame_count(frame_count), .overrun_count(overrun_count), .wd_err(wd_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic clear_inputs();
      game_done = 0; in_pos = '0; rd_finished = 0; rd_x = '0; rd_y = '0; rd_color = '0;
      ov_req = 0; ov_done = 0; ov_plot = 0; ov_x = '0; ov_y = '0; ov_color = '0;
   endtask

   // Leaves the bench at cycle 0 (resetn just released on a falling edge).
   task automatic apply_reset();
      resetn = 0;
      clear_inputs();
      repeat (2) @(negedge clock);
      resetn = 1;
   endtask

   // From cycle 0: game_step at 16, game_done at 19, SNAPSHOT at 20; returns at 21 (first RENDER cycle).
   task automatic start_frame();
      repeat (19) @(negedge clock);
      game_done = 1;
      @(negedge clock);
      game_done = 0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      resetn = 0;
      clear_inputs();
      in_pos = 36'hF_FFFF_FFFF; rd_x = 8'hAA; rd_y = 7'h55; rd_color = 12'hABC;
      game_done = 1; rd_finished = 1; ov_req = 1; ov_plot = 1; ov_x = 8'h5A;
      repeat (3) @(negedge clock);
      checks++; if (game_step !== 1'b0) begin failures++; $display("FAIL reset_game_step: got %0b want 0", game_step); end
      checks++; if (out_pos !== 36'h0) begin failures++; $display("FAIL reset_out_pos: got %0h want 0", out_pos); end
      checks++; if (rd_enable !== 1'b0) begin failures++; $display("FAIL reset_rd_enable: got %0b want 0", rd_enable); end
      checks++; if (ov_grant !== 1'b0) begin failures++; $display("FAIL reset_ov_grant: got %0b want 0", ov_grant); end
      checks++; if ({vga_plot, vga_x, vga_y, vga_color} !== 28'h0) begin failures++; $display("FAIL reset_vga: got %0h want 0", {vga_plot, vga_x, vga_y, vga_color}); end
      checks++; if (frame_count !== 16'h0) begin failures++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
      checks++; if (overrun_count !== 8'h0) begin failures++; $display("FAIL reset_overrun: got %0d want 0", overrun_count); end
      checks++; if (wd_err !== 1'b0) begin failures++; $display("FAIL reset_wd_err: got %0b want 0", wd_err); end
   endtask

   task automatic test_normal_frame();
      logic [35:0] snap;
      int plot_cnt, rden_cnt;
      apply_reset();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clock);
         checks++; if (game_step !== (k == 16)) begin failures++; $display("FAIL normal_step_k%0d: got %0b want %0b", k, game_step, (k == 16)); end
      end
      @(negedge clock);
      checks++; if (game_step !== 1'b0) begin failures++; $display("FAIL normal_step_single: got %0b want 0", game_step); end
      @(negedge clock);
      @(negedge clock);
      game_done = 1; rd_x = 8'hAB; rd_y = 7'h2C; rd_color = 12'h3DE;
      @(negedge clock);
      game_done = 0;
      checks++; if (rd_enable !== 1'b0) begin failures++; $display("FAIL normal_snapshot_rden: got %0b want 0", rd_enable); end
      checks++; if ({vga_plot, vga_x} !== 9'h0) begin failures++; $display("FAIL normal_snapshot_vga: got %0h want 0", {vga_plot, vga_x}); end
      snap = 36'h9_A5C3_7E1B;
      in_pos = snap;
      plot_cnt = 0; rden_cnt = 0;
      for (int r = 1; r <= 54; r++) begin
         @(negedge clock);
         if (vga_plot === 1'b1) plot_cnt++;
         if (rd_enable === 1'b1) rden_cnt++;
         if (r <= 50) begin
            checks++; if (out_pos !== snap) begin failures++; $display("FAIL normal_out_pos_r%0d: got %0h want %0h", r, out_pos, snap); end
            checks++; if ({vga_x, vga_y, vga_color} !== {rd_x, rd_y, rd_color}) begin failures++; $display("FAIL normal_vga_r%0d: got %0h want %0h", r, {vga_x, vga_y, vga_color}, {rd_x, rd_y, rd_color}); end
            in_pos = in_pos + 36'h0_1234_5679;
            rd_x = 8'(r * 7); rd_y = 7'(r * 3); rd_color = 12'(r * 41);
            rd_finished = (r == 50);
         end
         if (r == 51) begin
            rd_finished = 0;
            checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL normal_fc_overlay: got %0d want 0", frame_count); end
         end
         if (r == 52) begin
            checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL normal_frame_count: got %0d want 1", frame_count); end
            checks++; if (overrun_count !== 8'd3) begin failures++; $display("FAIL normal_overrun: got %0d want 3", overrun_count); end
            checks++; if (out_pos !== snap) begin failures++; $display("FAIL normal_out_pos_hold: got %0h want %0h", out_pos, snap); end
         end
      end
      checks++; if (plot_cnt !== 50) begin failures++; $display("FAIL normal_plot_cycles: got %0d want 50", plot_cnt); end
      checks++; if (rden_cnt !== 50) begin failures++; $display("FAIL normal_rden_cycles: got %0d want 50", rden_cnt); end
   endtask

   // game_done held high from the game_step cycle must not count in that cycle.
   task automatic test_game_done_pulse();
      apply_reset();
      repeat (16) @(negedge clock);
      checks++; if (game_step !== 1'b1) begin failures++; $display("FAIL pulse_step: got %0b want 1", game_step); end
      game_done = 1; in_pos = 36'h1_1111_1111;
      @(negedge clock);
      in_pos = 36'h2_2222_2222;
      @(negedge clock);
      checks++; if (rd_enable !== 1'b0) begin failures++; $display("FAIL pulse_rden_early: got %0b want 0", rd_enable); end
      in_pos = 36'h3_3333_3333;
      @(negedge clock);
      checks++; if (rd_enable !== 1'b1) begin failures++; $display("FAIL pulse_rden: got %0b want 1", rd_enable); end
      checks++; if (out_pos !== 36'h3_3333_3333) begin failures++; $display("FAIL pulse_snapshot: got %0h want 333333333", out_pos); end
      in_pos = 36'h4_4444_4444; game_done = 0; rd_finished = 1;
      @(negedge clock);
      rd_finished = 0;
      @(negedge clock);
      checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL pulse_frame_count: got %0d want 1", frame_count); end
      checks++; if (out_pos !== 36'h3_3333_3333) begin failures++; $display("FAIL pulse_out_pos_hold: got %0h want 333333333", out_pos); end
   endtask

   // RENDER 21..25, overlay granted 26..36, WAIT from 37.
   task automatic test_overlay();
      apply_reset();
      start_frame();
      ov_req = 1;
      for (int k = 21; k <= 38; k++) begin
         if (k > 21) @(negedge clock);
         checks++; if ((ov_grant & rd_enable) !== 1'b0) begin failures++; $display("FAIL ov_overlap_k%0d: grant %0b rden %0b", k, ov_grant, rd_enable); end
         if (k <= 25) begin
            checks++; if (ov_grant !== 1'b0) begin failures++; $display("FAIL ov_grant_in_render_k%0d: got %0b want 0", k, ov_grant); end
            rd_finished = (k == 25);
         end else if (k <= 36) begin
            rd_finished = 0;
            checks++; if (ov_grant !== 1'b1) begin failures++; $display("FAIL ov_grant_k%0d: got %0b want 1", k, ov_grant); end
            checks++; if ({vga_plot, vga_x, vga_y, vga_color} !== {ov_plot, ov_x, ov_y, ov_color}) begin failures++; $display("FAIL ov_vga_k%0d: got %0h want %0h", k, {vga_plot, vga_x, vga_y, vga_color}, {ov_plot, ov_x, ov_y, ov_color}); end
            if (k == 36) begin
               checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL ov_fc_before_done: got %0d want 0", frame_count); end
            end
            ov_plot = (k == 36) ? 1'b1 : k[0];
            ov_x = 8'(k * 5); ov_y = 7'(k); ov_color = 12'(k * 33);
            ov_done = (k == 36);
         end else if (k == 37) begin
            ov_done = 0;
            checks++; if (ov_grant !== 1'b0) begin failures++; $display("FAIL ov_grant_release: got %0b want 0", ov_grant); end
            checks++; if (vga_plot !== 1'b0) begin failures++; $display("FAIL ov_vga_after: got %0b want 0", vga_plot); end
            checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL ov_frame_count: got %0d want 1", frame_count); end
            ov_req = 0; ov_plot = 0;
         end else begin
            checks++; if (overrun_count !== 8'd1) begin failures++; $display("FAIL ov_overrun: got %0d want 1", overrun_count); end
         end
      end
   endtask

   // Continues from test_overlay at cycle 38: next frame UPDATE at 48, RENDER from 53.
   task automatic test_reset_mid_render();
      repeat (10) @(negedge clock);
      checks++; if (game_step !== 1'b1) begin failures++; $display("FAIL rst_second_step: got %0b want 1", game_step); end
      repeat (3) @(negedge clock);
      game_done = 1;
      @(negedge clock);
      game_done = 0;
      repeat (5) @(negedge clock);
      checks++; if ({rd_enable, frame_count} !== {1'b1, 16'd1}) begin failures++; $display("FAIL rst_pre_state: got %0h want 10001", {rd_enable, frame_count}); end
      resetn = 0;
      #1;
      checks++; if (rd_enable !== 1'b0) begin failures++; $display("FAIL rst_rd_enable: got %0b want 0", rd_enable); end
      checks++; if (vga_plot !== 1'b0) begin failures++; $display("FAIL rst_vga_plot: got %0b want 0", vga_plot); end
      checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_frame_count: got %0d want 0", frame_count); end
      checks++; if (overrun_count !== 8'd0) begin failures++; $display("FAIL rst_overrun: got %0d want 0", overrun_count); end
   endtask

   // RENDER 21..60 spans two ticks; the tick at 63 starts the next frame.
   task automatic test_overrun();
      apply_reset();
      start_frame();
      for (int k = 22; k <= 64; k++) begin
         @(negedge clock);
         rd_finished = (k == 60);
         if (k == 62) begin
            checks++; if (overrun_count !== 8'd2) begin failures++; $display("FAIL overrun_count: got %0d want 2", overrun_count); end
            checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL overrun_frame_count: got %0d want 1", frame_count); end
         end
         if (k >= 62) begin
            checks++; if (game_step !== (k == 64)) begin failures++; $display("FAIL overrun_step_k%0d: got %0b want %0b", k, game_step, (k == 64)); end
         end
      end
   endtask

   task automatic test_watchdog();
      int rden_cnt;
      apply_reset();
      start_frame();
      rden_cnt = 0;
      for (int k = 21; k <= 100; k++) begin
         if (k > 21) @(negedge clock);
         if (rd_enable === 1'b1) rden_cnt++;
`ifdef FRAME_WATCHDOG_EN
         if (k == 84 || k == 85) begin
            checks++; if ({rd_enable, wd_err} !== ((k == 84) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL wd_edge_k%0d: got %0b%0b", k, rd_enable, wd_err); end
         end
`else
         rd_finished = (k == 100);
`endif
      end
`ifdef FRAME_WATCHDOG_EN
      checks++; if (rden_cnt !== 64) begin failures++; $display("FAIL wd_rden_cycles: got %0d want 64", rden_cnt); end
      checks++; if (wd_err !== 1'b1) begin failures++; $display("FAIL wd_err_sticky: got %0b want 1", wd_err); end
      checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL wd_frame_count: got %0d want 0", frame_count); end
`else
      checks++; if (rden_cnt !== 80) begin failures++; $display("FAIL wd_rden_cycles: got %0d want 80", rden_cnt); end
      checks++; if (wd_err !== 1'b0) begin failures++; $display("FAIL wd_err_off: got %0b want 0", wd_err); end
      @(negedge clock);
      rd_finished = 0;
      @(negedge clock);
      checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL wd_off_frame_count: got %0d want 1", frame_count); end
`endif
      resetn = 0;
      #1;
      checks++; if (wd_err !== 1'b0) begin failures++; $display("FAIL wd_err_reset: got %0b want 0", wd_err); end
   endtask

   // game_done never arrives: every tick after the first lands in UPDATE.
   task automatic test_overrun_saturate();
      apply_reset();
      for (int k = 1; k <= 4816; k++) begin
         @(negedge clock);
         if (k == 32) begin
            checks++; if ({game_step, overrun_count} !== 9'd1) begin failures++; $display("FAIL sat_first: got %0h want 001", {game_step, overrun_count}); end
         end
         if (k == 4095) begin
            checks++; if (overrun_count !== 8'd254) begin failures++; $display("FAIL sat_254: got %0d want 254", overrun_count); end
         end
         if (k == 4096 || k == 4816) begin
            checks++; if (overrun_count !== 8'd255) begin failures++; $display("FAIL sat_255_k%0d: got %0d want 255", k, overrun_count); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal_frame();
      test_game_done_pulse();
      test_overlay();
      test_reset_mid_render();
      test_overrun();
      test_watchdog();
      test_overrun_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
